// File: rtl/sram_rw_req_ctrl_if.sv
// ---------------------------------------------------------------------------
// sram_rw_req_ctrl_if
//   Request/response stream bundle between a cache/scratchpad pipeline and
//   sram_rw_req_ctrl.
//
//   Request  (master -> slave): req_valid, req_write, req_addr, req_mask,
//                               req_data; slave returns req_ready.
//   Response (slave -> master): resp_valid, resp_data; master returns
//                               resp_ready.
//
//   master : the pipeline issuing requests and consuming read data
//   slave  : the SRAM request controller
// ---------------------------------------------------------------------------
interface sram_rw_req_ctrl_if #(
    parameter int ADDR_BITS = 9,
    parameter int DATA_BITS = 128,
    parameter int MASK_BITS = 4
);
    logic                 req_valid;
    logic                 req_ready;
    logic                 req_write;
    logic [ADDR_BITS-1:0] req_addr;
    logic [MASK_BITS-1:0] req_mask;
    logic [DATA_BITS-1:0] req_data;

    logic                 resp_valid;
    logic                 resp_ready;
    logic [DATA_BITS-1:0] resp_data;

    modport master (
        output req_valid, req_write, req_addr, req_mask, req_data, resp_ready,
        input  req_ready, resp_valid, resp_data
    );

    modport slave (
        input  req_valid, req_write, req_addr, req_mask, req_data, resp_ready,
        output req_ready, resp_valid, resp_data
    );
endinterface

// File: rtl/sram_rw_req_ctrl.sv
// ---------------------------------------------------------------------------
// sram_rw_req_ctrl
//   Initiator-side controller for a single-port RW0 SRAM macro with a
//   1-cycle registered read and per-lane write mask. Accepted requests are
//   passed straight onto the RW0 port in the accept cycle; read data returns
//   on RW0_rdata one cycle later, is pushed into an in-order response FIFO
//   and handed back over a ready/valid response channel. Read issue is
//   credit-limited so the FIFO can never overflow.
//
//   Ports:
//     clock, reset     : clock (also the SRAM RW0_clk), synchronous
//                        active-high reset
//     port (slave)     : request stream (req_*) and response stream (resp_*)
//     busy             : zero-init sweep in progress
//     RW0_addr/en/wmode/wmask/wdata : SRAM command outputs
//     RW0_rdata        : SRAM read data, valid the cycle after a read enable
//
//   Optional feature macro: SRAM_REQ_CTRL_ZERO_INIT_EN
//     When defined, every row 0..DEPTH-1 is written with zeros (full mask)
//     after reset, one row per cycle, before requests are accepted.
// ---------------------------------------------------------------------------
module sram_rw_req_ctrl #(
    parameter int ADDR_BITS    = 9,
    parameter int DEPTH        = 512,
    parameter int DATA_BITS    = 128,
    parameter int MASK_BITS    = 4,
    parameter int RESP_ENTRIES = 3
) (
    input  logic                 clock,
    input  logic                 reset,
    sram_rw_req_ctrl_if.slave    port,
    output logic                 busy,
    output logic [ADDR_BITS-1:0] RW0_addr,
    output logic                 RW0_en,
    output logic                 RW0_wmode,
    output logic [MASK_BITS-1:0] RW0_wmask,
    output logic [DATA_BITS-1:0] RW0_wdata,
    input  logic [DATA_BITS-1:0] RW0_rdata
);

    localparam int CNT_W = $clog2(RESP_ENTRIES + 1);
    localparam int PTR_W = $clog2(RESP_ENTRIES);
    localparam int OCC_W = CNT_W + 1;

    localparam logic [CNT_W-1:0] CNT_FULL  = CNT_W'(RESP_ENTRIES);
    localparam logic [OCC_W-1:0] OCC_LIMIT = OCC_W'(RESP_ENTRIES);
    localparam logic [PTR_W-1:0] PTR_LAST  = PTR_W'(RESP_ENTRIES - 1);

`ifdef SRAM_REQ_CTRL_ZERO_INIT_EN
    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_INIT = 1'b1
    } state_t;
    localparam state_t RESET_STATE = ST_INIT;
    localparam logic [ADDR_BITS-1:0] SWEEP_LAST = ADDR_BITS'(DEPTH - 1);

    logic [ADDR_BITS-1:0] sweep;
    logic [ADDR_BITS-1:0] sweep_nxt;
`else
    typedef enum logic [0:0] {
        ST_IDLE = 1'b0
    } state_t;
    localparam state_t RESET_STATE = ST_IDLE;
`endif

    state_t state;
    state_t state_nxt;

    logic                 req_ready_int;
    logic                 rd_accept;
    logic                 inflight_p1;
    logic [CNT_W-1:0]     count;
    logic [PTR_W-1:0]     wptr;
    logic [PTR_W-1:0]     rptr;
    logic [OCC_W-1:0]     occ;
    logic                 push;
    logic                 pop;
    logic [DATA_BITS-1:0] resp_mem [RESP_ENTRIES];

    // A read in flight inside the SRAM already owns a queue slot, so credit
    // is counted against queue entries plus the in-flight read.
    assign occ = {1'b0, count} + {{CNT_W{1'b0}}, inflight_p1};

    assign push = inflight_p1;
    assign pop  = port.resp_valid && port.resp_ready;

    // ---- stage p0: request accept / RW0 command ----
    always_comb begin
        state_nxt     = state;
        req_ready_int = 1'b0;
        busy          = 1'b0;
        RW0_en        = 1'b0;
        RW0_wmode     = port.req_write;
        RW0_addr      = port.req_addr;
        RW0_wmask     = port.req_mask;
        RW0_wdata     = port.req_data;
`ifdef SRAM_REQ_CTRL_ZERO_INIT_EN
        sweep_nxt     = sweep;
`endif
        if (!reset) begin
`ifdef SRAM_REQ_CTRL_ZERO_INIT_EN
            if (state == ST_INIT) begin
                busy      = 1'b1;
                RW0_en    = 1'b1;
                RW0_wmode = 1'b1;
                RW0_addr  = sweep;
                RW0_wmask = '1;
                RW0_wdata = '0;
                sweep_nxt = sweep + 1'b1;
                if (sweep == SWEEP_LAST) begin
                    state_nxt = ST_IDLE;
                end
            end else begin
                req_ready_int = (occ < OCC_LIMIT);
                RW0_en        = port.req_valid && req_ready_int;
            end
`else
            if (state == ST_IDLE) begin
                req_ready_int = (occ < OCC_LIMIT);
                RW0_en        = port.req_valid && req_ready_int;
            end
`endif
        end
    end

    assign rd_accept      = RW0_en && !RW0_wmode && (state == ST_IDLE);
    assign port.req_ready = req_ready_int;

    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= RESET_STATE;
            inflight_p1 <= 1'b0;
            count       <= '0;
            wptr        <= '0;
            rptr        <= '0;
`ifdef SRAM_REQ_CTRL_ZERO_INIT_EN
            sweep       <= '0;
`endif
        end else begin
            state       <= state_nxt;
            inflight_p1 <= rd_accept;
`ifdef SRAM_REQ_CTRL_ZERO_INIT_EN
            sweep       <= sweep_nxt;
`endif
            if (push && !pop) begin
                count <= count + 1'b1;
            end else if (!push && pop) begin
                count <= count - 1'b1;
            end
            if (push) begin
                wptr <= (wptr == PTR_LAST) ? '0 : wptr + 1'b1;
            end
            if (pop) begin
                rptr <= (rptr == PTR_LAST) ? '0 : rptr + 1'b1;
            end
        end
    end

    // ---- stage p1: SRAM read data capture into response queue ----
    // Storage is data only; pointers and count define which entries are live.
    always_ff @(posedge clock) begin
        if (push) begin
            resp_mem[wptr] <= RW0_rdata;
        end
    end

    // ---- stage p2: response output ----
    assign port.resp_valid = (count != '0) && !reset;
    assign port.resp_data  = resp_mem[rptr];

    a_no_overflow: assert property (
        @(posedge clock) disable iff (reset) !(push && (count == CNT_FULL))
    );

    a_addr_in_range: assert property (
        @(posedge clock) disable iff (reset) RW0_en |-> (int'(RW0_addr) < DEPTH)
    );

endmodule

// File: tb/tb_sram_rw_req_ctrl.sv
// ---------------------------------------------------------------------------
// tb_sram_rw_req_ctrl
//   Directed bench for sram_rw_req_ctrl with a behavioural RW0 SRAM
//   (1-cycle registered read, 32-bit write lanes). Each feature has its own
//   task; all stimulus changes right after a falling edge and outputs are
//   observed 1 time unit later, well clear of the rising edge.
// ---------------------------------------------------------------------------
module tb_sram_rw_req_ctrl;

    localparam int ADDR_BITS    = 9;
    localparam int DEPTH        = 512;
    localparam int DATA_BITS    = 128;
    localparam int MASK_BITS    = 4;
    localparam int RESP_ENTRIES = 3;
    localparam int LANE_W       = DATA_BITS / MASK_BITS;

    logic                 clock = 1'b0;
    logic                 reset = 1'b1;
    logic                 busy;
    logic [ADDR_BITS-1:0] RW0_addr;
    logic                 RW0_en;
    logic                 RW0_wmode;
    logic [MASK_BITS-1:0] RW0_wmask;
    logic [DATA_BITS-1:0] RW0_wdata;
    logic [DATA_BITS-1:0] RW0_rdata;

    int checks = 0;
    int errors = 0;

    sram_rw_req_ctrl_if #(
        .ADDR_BITS(ADDR_BITS),
        .DATA_BITS(DATA_BITS),
        .MASK_BITS(MASK_BITS)
    ) link ();

    sram_rw_req_ctrl #(
        .ADDR_BITS   (ADDR_BITS),
        .DEPTH       (DEPTH),
        .DATA_BITS   (DATA_BITS),
        .MASK_BITS   (MASK_BITS),
        .RESP_ENTRIES(RESP_ENTRIES)
    ) dut (
        .clock    (clock),
        .reset    (reset),
        .port     (link.slave),
        .busy     (busy),
        .RW0_addr (RW0_addr),
        .RW0_en   (RW0_en),
        .RW0_wmode(RW0_wmode),
        .RW0_wmask(RW0_wmask),
        .RW0_wdata(RW0_wdata),
        .RW0_rdata(RW0_rdata)
    );

    always #5 clock = ~clock;

    // Behavioural SRAM. Preloaded with a recognisable per-row pattern on the
    // first edge (reset is held then, so no command can collide with it).
    logic [DATA_BITS-1:0] sram [DEPTH];
    logic                 mem_loaded = 1'b0;

    always @(posedge clock) begin
        if (!mem_loaded) begin
            for (int i = 0; i < DEPTH; i++) begin
                sram[i] <= {4{32'h5A000000 | 32'(i)}};
            end
            mem_loaded <= 1'b1;
        end else if (RW0_en) begin
            if (RW0_wmode) begin
                for (int l = 0; l < MASK_BITS; l++) begin
                    if (RW0_wmask[l]) begin
                        sram[RW0_addr][l*LANE_W +: LANE_W] <= RW0_wdata[l*LANE_W +: LANE_W];
                    end
                end
            end else begin
                RW0_rdata <= sram[RW0_addr];
            end
        end
    end

    function automatic logic [DATA_BITS-1:0] bb_data(input int k);
        return {4{32'h10000000 + 32'(k)}};
    endfunction

    task automatic tick();
        @(negedge clock);
    endtask

    task automatic drive_idle();
        link.req_valid = 1'b0;
        link.req_write = 1'b0;
        link.req_addr  = '0;
        link.req_mask  = '0;
        link.req_data  = '0;
    endtask

    task automatic drive_req(input logic w, input logic [ADDR_BITS-1:0] a,
                             input logic [MASK_BITS-1:0] m, input logic [DATA_BITS-1:0] d);
        link.req_valid = 1'b1;
        link.req_write = w;
        link.req_addr  = a;
        link.req_mask  = m;
        link.req_data  = d;
    endtask

    task automatic test_reset();
        repeat (3) tick();
        drive_req(1'b0, 9'h010, 4'h0, '0);
        link.resp_ready = 1'b1;
        #1;
        checks++;
        if (link.req_ready !== 1'b0) begin
            errors++; $display("FAIL reset_req_ready: got %b want 0", link.req_ready);
        end
        checks++;
        if (link.resp_valid !== 1'b0) begin
            errors++; $display("FAIL reset_resp_valid: got %b want 0", link.resp_valid);
        end
        checks++;
        if (RW0_en !== 1'b0) begin
            errors++; $display("FAIL reset_rw0_en: got %b want 0", RW0_en);
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++; $display("FAIL reset_busy: got %b want 0", busy);
        end
        tick();
    endtask

    task automatic test_init();
        drive_idle();
        reset = 1'b0;
`ifdef SRAM_REQ_CTRL_ZERO_INIT_EN
        for (int i = 0; i < DEPTH; i++) begin
            #1;
            checks++;
            if (RW0_en !== 1'b1 || RW0_wmode !== 1'b1 || RW0_addr !== ADDR_BITS'(i) ||
                RW0_wmask !== 4'hF || RW0_wdata !== '0 || link.req_ready !== 1'b0 || busy !== 1'b1) begin
                errors++;
                $display("FAIL init_sweep cycle %0d: en=%b wmode=%b addr=%0d mask=%h wdata_zero=%b ready=%b busy=%b, want en=1 wmode=1 addr=%0d mask=f wdata_zero=1 ready=0 busy=1",
                         i, RW0_en, RW0_wmode, RW0_addr, RW0_wmask, (RW0_wdata == '0), link.req_ready, busy, i);
            end
            tick();
        end
`endif
        #1;
        checks++;
        if (link.req_ready !== 1'b1 || busy !== 1'b0 || RW0_en !== 1'b0) begin
            errors++;
            $display("FAIL init_done: ready=%b busy=%b en=%b, want ready=1 busy=0 en=0",
                     link.req_ready, busy, RW0_en);
        end
        tick();
    endtask

    task automatic test_masked_write();
        logic [DATA_BITS-1:0] exp_mw;
        logic [DATA_BITS-1:0] exp_1f5;
        exp_mw = 128'h01234567_89ABCDEF_DEADBEEF_11111111;
`ifdef SRAM_REQ_CTRL_ZERO_INIT_EN
        exp_1f5 = '0;
`else
        exp_1f5 = 128'h5A0001F5_5A0001F5_5A0001F5_5A0001F5;
`endif
        link.resp_ready = 1'b1;
        drive_req(1'b1, 9'h0A3, 4'b1111, 128'h01234567_89ABCDEF_DEADBEEF_CAFEF00D);
        #1;
        checks++;
        if (link.req_ready !== 1'b1) begin
            errors++; $display("FAIL mw_ready: got %b want 1", link.req_ready);
        end
        tick();
        drive_req(1'b1, 9'h0A3, 4'b0001, 128'hFFFFFFFF_FFFFFFFF_FFFFFFFF_11111111);
        tick();
        drive_req(1'b0, 9'h0A3, 4'b0000, '0);
        tick();
        drive_req(1'b0, 9'h1F5, 4'b0000, '0);
        #1;
        checks++;
        if (link.resp_valid !== 1'b0) begin
            errors++; $display("FAIL mw_latency: resp_valid got %b want 0 one cycle after accept", link.resp_valid);
        end
        tick();
        drive_idle();
        #1;
        checks++;
        if (link.resp_valid !== 1'b1 || link.resp_data !== exp_mw) begin
            errors++; $display("FAIL mw_read: valid=%b data=%h, want valid=1 data=%h", link.resp_valid, link.resp_data, exp_mw);
        end
        tick();
        #1;
        checks++;
        if (link.resp_valid !== 1'b1 || link.resp_data !== exp_1f5) begin
            errors++; $display("FAIL read_1f5: valid=%b data=%h, want valid=1 data=%h", link.resp_valid, link.resp_data, exp_1f5);
        end
        tick();
        #1;
        checks++;
        if (link.resp_valid !== 1'b0) begin
            errors++; $display("FAIL mw_drained: resp_valid got %b want 0", link.resp_valid);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        link.resp_ready = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            drive_req(1'b1, ADDR_BITS'(k), 4'hF, bb_data(k));
            tick();
        end
        for (int c = 0; c < 7; c++) begin
            if (c < 4) drive_req(1'b0, ADDR_BITS'(c + 1), 4'h0, '0);
            else       drive_idle();
            #1;
            if (c < 4) begin
                checks++;
                if (link.req_ready !== 1'b1) begin
                    errors++; $display("FAIL b2b_ready cycle %0d: got %b want 1", c, link.req_ready);
                end
            end
            checks++;
            if (c >= 2 && c <= 5) begin
                if (link.resp_valid !== 1'b1 || link.resp_data !== bb_data(c - 1)) begin
                    errors++; $display("FAIL b2b_resp cycle %0d: valid=%b data=%h, want valid=1 data=%h",
                                       c, link.resp_valid, link.resp_data, bb_data(c - 1));
                end
            end else if (link.resp_valid !== 1'b0) begin
                errors++; $display("FAIL b2b_resp cycle %0d: valid=%b want 0", c, link.resp_valid);
            end
            tick();
        end
    endtask

    task automatic test_backpressure();
        logic [7:0] exp_ready;
        logic [7:0] exp_valid;
        int         accepted;
        exp_ready = 8'b1000_0111;
        exp_valid = 8'b1111_1100;
        accepted  = 0;
        for (int c = 0; c < 8; c++) begin
            drive_req(1'b0, ADDR_BITS'((c < 3) ? c + 1 : 4), 4'h0, '0);
            link.resp_ready = (c == 6);
            #1;
            if (c < 6 && link.req_ready === 1'b1) accepted++;
            checks++;
            if (link.req_ready !== exp_ready[c]) begin
                errors++; $display("FAIL bp_ready cycle %0d: got %b want %b", c, link.req_ready, exp_ready[c]);
            end
            checks++;
            if (link.resp_valid !== exp_valid[c]) begin
                errors++; $display("FAIL bp_valid cycle %0d: got %b want %b", c, link.resp_valid, exp_valid[c]);
            end else if (exp_valid[c] && link.resp_data !== bb_data((c == 7) ? 2 : 1)) begin
                errors++; $display("FAIL bp_head cycle %0d: got %h want %h", c, link.resp_data, bb_data((c == 7) ? 2 : 1));
            end
            tick();
        end
        checks++;
        if (accepted != 3) begin
            errors++; $display("FAIL bp_accepted: got %0d want 3", accepted);
        end
        drive_idle();
        link.resp_ready = 1'b1;
        #1;
        checks++;
        if (link.req_ready !== 1'b0) begin
            errors++; $display("FAIL bp_full_again: req_ready got %b want 0", link.req_ready);
        end
        for (int k = 2; k <= 5; k++) begin
            if (k > 2) #1;
            checks++;
            if (k <= 4) begin
                if (link.resp_valid !== 1'b1 || link.resp_data !== bb_data(k)) begin
                    errors++; $display("FAIL bp_drain %0d: valid=%b data=%h, want valid=1 data=%h",
                                       k, link.resp_valid, link.resp_data, bb_data(k));
                end
            end else if (link.resp_valid !== 1'b0) begin
                errors++; $display("FAIL bp_drain_empty: valid=%b want 0", link.resp_valid);
            end
            tick();
        end
    endtask

    task automatic test_raw();
        logic [DATA_BITS-1:0] d7;
        d7 = 128'hA5A5A5A5_5A5A5A5A_0F0F0F0F_F0F0F0F0;
        link.resp_ready = 1'b1;
        drive_req(1'b1, 9'h007, 4'hF, d7);
        tick();
        drive_req(1'b0, 9'h007, 4'h0, '0);
        tick();
        drive_idle();
        #1;
        checks++;
        if (link.resp_valid !== 1'b0) begin
            errors++; $display("FAIL raw_latency: resp_valid got %b want 0", link.resp_valid);
        end
        tick();
        #1;
        checks++;
        if (link.resp_valid !== 1'b1 || link.resp_data !== d7) begin
            errors++; $display("FAIL raw_data: valid=%b data=%h, want valid=1 data=%h", link.resp_valid, link.resp_data, d7);
        end
        tick();
    endtask

    task automatic test_reset_midop();
        link.resp_ready = 1'b0;
        drive_req(1'b0, 9'h001, 4'h0, '0);
        #1;
        checks++;
        if (link.req_ready !== 1'b1) begin
            errors++; $display("FAIL rm_accept1: req_ready got %b want 1", link.req_ready);
        end
        tick();
        drive_req(1'b0, 9'h002, 4'h0, '0);
        #1;
        checks++;
        if (link.req_ready !== 1'b1) begin
            errors++; $display("FAIL rm_accept2: req_ready got %b want 1", link.req_ready);
        end
        tick();
        drive_idle();
        reset = 1'b1;
        #1;
        checks++;
        if (link.resp_valid !== 1'b0 || link.req_ready !== 1'b0) begin
            errors++; $display("FAIL rm_in_reset: valid=%b ready=%b, want valid=0 ready=0", link.resp_valid, link.req_ready);
        end
        tick();
        reset = 1'b0;
        link.resp_ready = 1'b1;
        #1;
        checks++;
`ifdef SRAM_REQ_CTRL_ZERO_INIT_EN
        if (RW0_en !== 1'b1 || RW0_wmode !== 1'b1 || RW0_addr !== 9'h000 || busy !== 1'b1) begin
            errors++; $display("FAIL rm_sweep_restart: en=%b wmode=%b addr=%0d busy=%b, want en=1 wmode=1 addr=0 busy=1",
                               RW0_en, RW0_wmode, RW0_addr, busy);
        end
`else
        if (busy !== 1'b0 || link.req_ready !== 1'b1) begin
            errors++; $display("FAIL rm_idle: busy=%b ready=%b, want busy=0 ready=1", busy, link.req_ready);
        end
`endif
        for (int c = 0; c < 6; c++) begin
            if (c > 0) #1;
            checks++;
            if (link.resp_valid !== 1'b0) begin
                errors++; $display("FAIL rm_no_stale cycle %0d: resp_valid got %b want 0", c, link.resp_valid);
            end
            tick();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    initial begin
        drive_idle();
        link.resp_ready = 1'b0;
        test_reset();
        test_init();
        test_masked_write();
        test_back_to_back();
        test_backpressure();
        test_raw();
        test_reset_midop();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/sram_rw_req_ctrl.md
Name: sram_rw_req_ctrl

Overview:
- Initiator-side controller for a single-port RW0 behavioural SRAM macro: 1-cycle registered read, per-lane write mask.
- Converts a ready/valid request stream (read or masked write) into RW0_en/RW0_wmode/RW0_addr/RW0_wmask/RW0_wdata.
- Captures RW0_rdata one cycle after each read and returns it in order through a ready/valid response queue with credit-based backpressure.
- Sits between a cache/scratchpad pipeline and a data_arrays/tag_array-class SRAM; top level ties the SRAM RW0_clk to clock.

Parameters:
- ADDR_BITS, 9, SRAM address width.
- DEPTH, 512, number of SRAM rows (≤ 2^ADDR_BITS).
- DATA_BITS, 128, row width.
- MASK_BITS, 4, write-mask lanes; DATA_BITS divisible by MASK_BITS.
- RESP_ENTRIES, 3, response queue depth; minimum 2; 3 gives full read throughput.

Ports:
- clock  in  1  clock
- reset  in  1  synchronous, active-high reset
- req_valid  in  1  request valid
- req_ready  out  1  request accepted when valid&&ready
- req_write  in  1  1=write, 0=read
- req_addr  in  ADDR_BITS  row address
- req_mask  in  MASK_BITS  write lane enables (ignored for reads)
- req_data  in  DATA_BITS  write data
- resp_valid  out  1  read data available
- resp_ready  in  1  consumer accepts response
- resp_data  out  DATA_BITS  read data, in request order
- busy  out  1  init sweep in progress
- RW0_addr  out  ADDR_BITS  to SRAM
- RW0_en  out  1  to SRAM
- RW0_wmode  out  1  to SRAM
- RW0_wmask  out  MASK_BITS  to SRAM
- RW0_wdata  out  DATA_BITS  to SRAM
- RW0_rdata  in  DATA_BITS  from SRAM, valid the cycle after a read enable

Behaviour:
- Reset, while reset=1: req_ready=0, resp_valid=0, RW0_en=0, busy=0. Queue cleared, in-flight flag cleared, state set to INIT (feature on) or IDLE. Mid-operation reset discards all queued and in-flight reads; no response is ever produced for them.
- States: INIT (feature only), IDLE. No other states.
- Occupancy: occ = queue count + inflight. inflight is a 1-bit register, set the cycle after a read is accepted and cleared on the following edge.
- req_ready = (state==IDLE) && (occ < RESP_ENTRIES). Registered terms only; no combinational path from resp_ready or req_valid.
- Accept cycle T (IDLE):
  - RW0_en = req_valid&&req_ready.
  - RW0_wmode = req_write.
  - RW0_addr = req_addr, RW0_wmask = req_mask, RW0_wdata = req_data, all passed straight through.
- Idle cycles: RW0_en=0. Other RW0 outputs still follow the req fields and are don't-care.
- Read accepted at T:
  - inflight=1 during T+1.
  - RW0_rdata is pushed to the queue at the end of T+1.
  - resp_valid=1 no earlier than T+2.
  - Minimum latency from accept to resp_valid is 2 cycles.
- Write accepted at T: commits at the T edge. No response. Does not consume occupancy.
- Read-after-write to the same address in consecutive cycles returns the new data.
- Queue:
  - FIFO of RESP_ENTRIES; resp_data = head entry.
  - Push and pop in the same cycle are both allowed, including at count==RESP_ENTRIES-1 and count==0 with a push.
  - Pop on an empty queue cannot occur (resp_valid=0).
  - Overflow is impossible by the credit rule. Implementation carries an assertion that push never happens when count==RESP_ENTRIES.
- A pop frees credit visible to req_ready on the next cycle.
- Pointer and count wrap modulo RESP_ENTRIES; count width is clog2(RESP_ENTRIES+1).

Optional Feature:
- Macro SRAM_REQ_CTRL_ZERO_INIT_EN.
- Defined:
  - After reset deasserts, state=INIT and busy=1.
  - Each cycle the block drives RW0_en=1, RW0_wmode=1, RW0_wmask=all-ones, RW0_wdata=0, RW0_addr=sweep counter.
  - The sweep counter runs 0..DEPTH-1, one row per cycle.
  - After writing row DEPTH-1 the state moves to IDLE; busy=0 and req_ready=1 the next cycle, i.e. the DEPTH-th cycle after reset release.
  - req_ready=0 throughout INIT.
  - Reset during INIT restarts the sweep at row 0.
- Undefined: no INIT state, no sweep counter, busy tied 0, IDLE directly after reset.

Test Plan:
- Feature on, DEPTH=512: release reset at cycle 0 -> RW0_en=1 with wmode=1 and addr 0..511 over cycles 0..511; req_ready=1 and busy=0 at cycle 512; read of addr 0x1F5 returns 0.
- Write addr 0x0A3 data 0x…DEADBEEF_CAFEF00D mask 4'b1111, then write the same addr with mask 4'b0001 data low word 0x11111111, then read -> resp_data low word 0x11111111, upper lanes unchanged.
- Back-to-back reads of addr 1,2,3,4 with resp_ready=1 held: req_ready stays 1 every cycle; responses appear on cycles T+2..T+5 in order 1,2,3,4.
- resp_ready=0, issue 5 reads -> exactly 3 accepted (req_ready drops after occ reaches 3); resp_valid held with head data stable. Raise resp_ready for one cycle -> one pop, req_ready=1 on the next cycle.
- Write addr 7 at T, read addr 7 at T+1 -> response equals the written data.
- Two reads accepted, assert reset on the cycle the first response is pushed -> resp_valid=0 after reset, no stale response ever emitted; feature on: sweep restarts at addr 0.
